// File: rtl/time_keeper.sv
// Time-of-day counter: prescales clk to a 1 Hz tick and keeps hh:mm:ss packed as
// hhhhh_mmmmmm_ssssss, with a validated synchronous overwrite port.
module time_keeper #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        time_ow,
  input  logic [16:0] time_in,
  output logic [16:0] time_out,
  output logic        sec_tick,
  output logic        new_day,
  output logic        load_err
);

  localparam int PSC_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(CLK_FREQ - 1);

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
  } tod_t;

  tod_t             cur, nxt, ld;
  logic [PSC_W-1:0] psc;
  logic             tc, load_ok;
  logic             sec_w, min_w, hr_w;

  assign ld       = tod_t'(time_in);
  assign tc       = en && (psc == PSC_MAX);
  assign load_ok  = (ld.hr <= 5'd23) && (ld.min <= 6'd59) && (ld.sec <= 6'd59);
  assign time_out = cur;

  // Ripple-carry increment with explicit wrap per field.
  always_comb begin
    sec_w   = (cur.sec == 6'd59);
    min_w   = (cur.min == 6'd59);
    hr_w    = (cur.hr == 5'd23);
    nxt     = cur;
    nxt.sec = sec_w ? 6'd0 : cur.sec + 6'd1;
    if (sec_w) begin
      nxt.min = min_w ? 6'd0 : cur.min + 6'd1;
      if (min_w)
        nxt.hr = hr_w ? 5'd0 : cur.hr + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= '0;
      psc      <= '0;
      sec_tick <= 1'b0;
      new_day  <= 1'b0;
      load_err <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      new_day  <= 1'b0;
      load_err <= 1'b0;
      if (time_ow) begin
        // A load never counts as a tick, even on a TC cycle.
        if (load_ok) begin
          cur <= ld;
          psc <= '0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tc) begin
        psc      <= '0;
        cur      <= nxt;
        sec_tick <= 1'b1;
        new_day  <= sec_w && min_w && hr_w;
      end else if (en) begin
        psc <= psc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// Self-checking bench for time_keeper: directed test-plan scenarios plus random
// traffic, compared every cycle against a seconds-of-day reference model.
module tb_time_keeper;

  localparam int CF = 4;

  logic        clk = 1'b0;
  logic        rst, en, time_ow;
  logic [16:0] time_in;
  logic [16:0] time_out;
  logic        sec_tick, new_day, load_err;

  int checks   = 0;
  int failures = 0;

  // Reference state: time as seconds since midnight, prescaler as a plain count.
  int m_tod, m_psc;
  bit m_tick, m_nday, m_lerr;
  int tick_cnt, nday_cnt;

  time_keeper #(.CLK_FREQ(CF)) dut (
    .clk(clk), .rst(rst), .en(en), .time_ow(time_ow), .time_in(time_in),
    .time_out(time_out), .sec_tick(sec_tick), .new_day(new_day), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] pack(input int tod);
    logic [4:0] h;
    logic [5:0] m, s;
    h = 5'(tod / 3600);
    m = 6'((tod / 60) % 60);
    s = 6'(tod % 60);
    return {h, m, s};
  endfunction

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm, ss;
    hh = 5'(h); mm = 6'(m); ss = 6'(s);
    return {hh, mm, ss};
  endfunction

  task automatic model(input logic r, input logic e, input logic ow, input logic [16:0] ti);
    int h, m, s;
    m_tick = 0; m_nday = 0; m_lerr = 0;
    h = int'(ti[16:12]); m = int'(ti[11:6]); s = int'(ti[5:0]);
    if (r) begin
      m_tod = 0; m_psc = 0;
    end else if (ow) begin
      if (h <= 23 && m <= 59 && s <= 59) begin
        m_tod = h * 3600 + m * 60 + s;
        m_psc = 0;
      end else begin
        m_lerr = 1;
      end
    end else if (e) begin
      if (m_psc == CF - 1) begin
        m_psc  = 0;
        m_tod  = (m_tod + 1) % 86400;
        m_tick = 1;
        m_nday = (m_tod == 0);
      end else begin
        m_psc++;
      end
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input logic r, input logic e, input logic ow, input logic [16:0] ti);
    rst = r; en = e; time_ow = ow; time_in = ti;
    @(posedge clk);
    model(r, e, ow, ti);
    #1;
    chk("time_out", 32'(time_out), 32'(pack(m_tod)));
    chk("sec_tick", 32'(sec_tick), 32'(m_tick));
    chk("new_day",  32'(new_day),  32'(m_nday));
    chk("load_err", 32'(load_err), 32'(m_lerr));
    if (sec_tick) tick_cnt++;
    if (new_day)  nday_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 17'd0);
  endtask

  initial begin
    m_tod = 0; m_psc = 0;
    rst = 1'b1; en = 1'b0; time_ow = 1'b0; time_in = '0;

    // 1: reset state, then three ticks in 12 cycles
    step(1'b1, 1'b0, 1'b0, 17'd0);
    chk("rst_time", 32'(time_out), 32'd0);
    tick_cnt = 0;
    run(3);
    chk("no_early_tick", 32'(tick_cnt), 32'd0);
    run(1);
    chk("tick_c4", 32'(sec_tick), 32'd1);
    run(8);
    chk("tick_count12", 32'(tick_cnt), 32'd3);
    chk("time_3s", 32'(time_out), 32'(hms(0, 0, 3)));

    // 2: midnight wrap
    nday_cnt = 0;
    step(1'b0, 1'b1, 1'b1, hms(23, 59, 59));
    run(4);
    chk("wrap_time", 32'(time_out), 32'd0);
    chk("wrap_nday", 32'(new_day), 32'd1);
    run(8);
    chk("nday_once", 32'(nday_cnt), 32'd1);

    // 3: minute and hour carries
    nday_cnt = 0;
    step(1'b0, 1'b1, 1'b1, hms(12, 34, 59));
    run(4);
    chk("min_carry", 32'(time_out), 32'(hms(12, 35, 0)));
    step(1'b0, 1'b1, 1'b1, hms(12, 59, 59));
    run(4);
    chk("hr_carry", 32'(time_out), 32'(hms(13, 0, 0)));
    chk("no_nday", 32'(nday_cnt), 32'd0);

    // 4: rejected loads
    step(1'b0, 1'b1, 1'b1, hms(24, 0, 0));
    chk("err_hr", 32'(load_err), 32'd1);
    step(1'b0, 1'b1, 1'b0, 17'd0);
    step(1'b0, 1'b1, 1'b1, hms(1, 60, 0));
    chk("err_min", 32'(load_err), 32'd1);
    step(1'b0, 1'b1, 1'b0, 17'd0);
    step(1'b0, 1'b1, 1'b1, hms(1, 2, 63));
    chk("err_sec", 32'(load_err), 32'd1);
    chk("err_hold", 32'(time_out), 32'(hms(13, 0, 0)));

    // 5: load on the TC cycle wins over the tick
    step(1'b1, 1'b0, 1'b0, 17'd0);
    run(3);
    step(1'b0, 1'b1, 1'b1, hms(5, 0, 0));
    chk("tc_load_time", 32'(time_out), 32'(hms(5, 0, 0)));
    chk("tc_load_tick", 32'(sec_tick), 32'd0);
    tick_cnt = 0;
    run(3);
    chk("tc_load_gap", 32'(tick_cnt), 32'd0);
    run(1);
    chk("tc_load_next", 32'(sec_tick), 32'd1);

    // 6: enable pause keeps the partial second; reset discards it
    step(1'b1, 1'b0, 1'b0, 17'd0);
    run(2);
    tick_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 17'd0);
    chk("en_low_tick", 32'(tick_cnt), 32'd0);
    run(1);
    chk("reen_c1", 32'(sec_tick), 32'd0);
    run(1);
    chk("reen_c2", 32'(sec_tick), 32'd1);
    run(2);
    step(1'b1, 1'b1, 1'b0, 17'd0);
    tick_cnt = 0;
    run(3);
    chk("rst_mid_gap", 32'(tick_cnt), 32'd0);
    run(1);
    chk("rst_mid_tick", 32'(sec_tick), 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic        r, e, ow;
      logic [16:0] ti;
      r  = ($urandom_range(0, 99) == 0);
      e  = ($urandom_range(0, 9) != 0);
      ow = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 2))
        0:       ti = 17'($urandom);
        1:       ti = hms($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
        default: ti = hms(23, 59, $urandom_range(50, 59));
      endcase
      step(r, e, ow, ti);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
